// File: rtl/bus_pkg.sv
// Shared types for the master-to-slaves demultiplexer: FSM state encoding and command values.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_FIRST,
    BUSY_SECOND,
    RESP
  } state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Counts cycles spent waiting on a slave ack; expired flags the final allowed cycle.
module bus_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  logic [CW-1:0] count;

  // Saturates at the terminal count; a zero TIMEOUT_CYCLES never expires.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = TIMEOUT_EN && enable && (count == LAST);

endmodule

// File: rtl/demux_master.sv
// Routes one master's req/ack transaction to the first or second slave by address decode,
// terminating unmapped or hung accesses with an error response.
module demux_master
  import bus_pkg::*;
#(
  parameter int                 ADDR_W         = 32,
  parameter int                 DATA_W         = 32,
  parameter logic [ADDR_W-1:0]  BASE_FIRST     = 32'h0000_0000,
  parameter logic [ADDR_W-1:0]  MASK_FIRST     = 32'h8000_0000,
  parameter logic [ADDR_W-1:0]  BASE_SECOND    = 32'h8000_0000,
  parameter logic [ADDR_W-1:0]  MASK_SECOND    = 32'h8000_0000,
  parameter int                 TIMEOUT_CYCLES = 16,
  parameter logic [DATA_W-1:0]  ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              cmd_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              ack_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic              err_out,
  output logic              req_out_first,
  output logic [ADDR_W-1:0] addr_out_first,
  output logic              cmd_out_first,
  output logic [DATA_W-1:0] wdata_out_first,
  input  logic              ack_in_first,
  input  logic [DATA_W-1:0] rdata_in_first,
  output logic              req_out_second,
  output logic [ADDR_W-1:0] addr_out_second,
  output logic              cmd_out_second,
  output logic [DATA_W-1:0] wdata_out_second,
  input  logic              ack_in_second,
  input  logic [DATA_W-1:0] rdata_in_second
);

  state_t state;
  logic   hit_first;
  logic   hit_second;
  logic   busy;
  logic   expired;

  assign hit_first  = ((addr_in & MASK_FIRST) == BASE_FIRST);
  assign hit_second = ((addr_in & MASK_SECOND) == BASE_SECOND);
  assign busy       = (state == BUSY_FIRST) || (state == BUSY_SECOND);

  bus_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (!busy),
    .enable (busy),
    .expired(expired)
  );

  // The slave-side output registers double as the latched copy of the accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      ack_out          <= 1'b0;
      err_out          <= 1'b0;
      rdata_out        <= '0;
      req_out_first    <= 1'b0;
      addr_out_first   <= '0;
      cmd_out_first    <= 1'b0;
      wdata_out_first  <= '0;
      req_out_second   <= 1'b0;
      addr_out_second  <= '0;
      cmd_out_second   <= 1'b0;
      wdata_out_second <= '0;
    end else begin
      ack_out   <= 1'b0;
      err_out   <= 1'b0;
      rdata_out <= '0;
      case (state)
        IDLE: begin
          if (req_in) begin
            if (hit_first) begin
              state           <= BUSY_FIRST;
              req_out_first   <= 1'b1;
              addr_out_first  <= addr_in;
              cmd_out_first   <= cmd_in;
              wdata_out_first <= wdata_in;
            end else if (hit_second) begin
              state            <= BUSY_SECOND;
              req_out_second   <= 1'b1;
              addr_out_second  <= addr_in;
              cmd_out_second   <= cmd_in;
              wdata_out_second <= wdata_in;
            end else begin
              state     <= RESP;
              ack_out   <= 1'b1;
              err_out   <= 1'b1;
              rdata_out <= ERR_RDATA;
            end
          end
        end
        BUSY_FIRST: begin
          if (ack_in_first || expired) begin
            state           <= RESP;
            ack_out         <= 1'b1;
            req_out_first   <= 1'b0;
            addr_out_first  <= '0;
            cmd_out_first   <= 1'b0;
            wdata_out_first <= '0;
            // A same-cycle ack beats the timeout.
            if (ack_in_first) begin
              rdata_out <= (cmd_out_first == CMD_READ) ? rdata_in_first : '0;
            end else begin
              err_out   <= 1'b1;
              rdata_out <= ERR_RDATA;
            end
          end
        end
        BUSY_SECOND: begin
          if (ack_in_second || expired) begin
            state            <= RESP;
            ack_out          <= 1'b1;
            req_out_second   <= 1'b0;
            addr_out_second  <= '0;
            cmd_out_second   <= 1'b0;
            wdata_out_second <= '0;
            if (ack_in_second) begin
              rdata_out <= (cmd_out_second == CMD_READ) ? rdata_in_second : '0;
            end else begin
              err_out   <= 1'b1;
              rdata_out <= ERR_RDATA;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_master.sv
// Directed bench: instance a uses default decode, instance b a narrowed second-slave window.
module tb_demux_master;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_in, cmd_in;
  logic [31:0] addr_in, wdata_in;
  logic        ack_out, err_out;
  logic [31:0] rdata_out;
  logic        req_out_first, cmd_out_first, ack_in_first;
  logic [31:0] addr_out_first, wdata_out_first, rdata_in_first;
  logic        req_out_second, cmd_out_second, ack_in_second;
  logic [31:0] addr_out_second, wdata_out_second, rdata_in_second;

  logic        b_req_in, b_cmd_in;
  logic [31:0] b_addr_in, b_wdata_in;
  logic        b_ack_out, b_err_out;
  logic [31:0] b_rdata_out;
  logic        b_req_out_first, b_cmd_out_first, b_ack_in_first;
  logic [31:0] b_addr_out_first, b_wdata_out_first, b_rdata_in_first;
  logic        b_req_out_second, b_cmd_out_second, b_ack_in_second;
  logic [31:0] b_addr_out_second, b_wdata_out_second, b_rdata_in_second;

  int n_compared   = 0;
  int n_mismatched = 0;
  int hi_cycles;

  always #5 clk = ~clk;

  demux_master dut_a (
    .clk(clk), .rst(rst),
    .req_in(req_in), .addr_in(addr_in), .cmd_in(cmd_in), .wdata_in(wdata_in),
    .ack_out(ack_out), .rdata_out(rdata_out), .err_out(err_out),
    .req_out_first(req_out_first), .addr_out_first(addr_out_first),
    .cmd_out_first(cmd_out_first), .wdata_out_first(wdata_out_first),
    .ack_in_first(ack_in_first), .rdata_in_first(rdata_in_first),
    .req_out_second(req_out_second), .addr_out_second(addr_out_second),
    .cmd_out_second(cmd_out_second), .wdata_out_second(wdata_out_second),
    .ack_in_second(ack_in_second), .rdata_in_second(rdata_in_second)
  );

  demux_master #(
    .BASE_SECOND(32'h9000_0000),
    .MASK_SECOND(32'hF000_0000)
  ) dut_b (
    .clk(clk), .rst(rst),
    .req_in(b_req_in), .addr_in(b_addr_in), .cmd_in(b_cmd_in), .wdata_in(b_wdata_in),
    .ack_out(b_ack_out), .rdata_out(b_rdata_out), .err_out(b_err_out),
    .req_out_first(b_req_out_first), .addr_out_first(b_addr_out_first),
    .cmd_out_first(b_cmd_out_first), .wdata_out_first(b_wdata_out_first),
    .ack_in_first(b_ack_in_first), .rdata_in_first(b_rdata_in_first),
    .req_out_second(b_req_out_second), .addr_out_second(b_addr_out_second),
    .cmd_out_second(b_cmd_out_second), .wdata_out_second(b_wdata_out_second),
    .ack_in_second(b_ack_in_second), .rdata_in_second(b_rdata_in_second)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic [31:0] addr,
                               input logic cmd, input logic [31:0] wdata);
    req_in   = req;
    addr_in  = addr;
    cmd_in   = cmd;
    wdata_in = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    ack_in_first = 1'b0;  rdata_in_first = '0;
    ack_in_second = 1'b0; rdata_in_second = '0;
    b_req_in = 1'b0; b_addr_in = '0; b_cmd_in = 1'b0; b_wdata_in = '0;
    b_ack_in_first = 1'b0;  b_rdata_in_first = '0;
    b_ack_in_second = 1'b0; b_rdata_in_second = '0;

    // Reset state
    tick(); tick();
    checkOutput("rst_ack", ack_out, 0);
    checkOutput("rst_err", err_out, 0);
    checkOutput("rst_rdata", rdata_out, 0);
    checkOutput("rst_req_first", req_out_first, 0);
    checkOutput("rst_req_second", req_out_second, 0);
    checkOutput("rst_addr_first", addr_out_first, 0);
    rst = 1'b0;
    tick();

    // Read from first slave, acked on its first request cycle
    applyStimulus(1'b1, 32'h3333_3333, 1'b0, 32'h0);
    tick();
    checkOutput("rd1_req_first", req_out_first, 1);
    checkOutput("rd1_addr_first", addr_out_first, 32'h3333_3333);
    checkOutput("rd1_req_second", req_out_second, 0);
    checkOutput("rd1_ack_early", ack_out, 0);
    ack_in_first = 1'b1; rdata_in_first = 32'h7575_7575;
    tick();
    checkOutput("rd1_req_first_drop", req_out_first, 0);
    checkOutput("rd1_ack", ack_out, 1);
    checkOutput("rd1_err", err_out, 0);
    checkOutput("rd1_rdata", rdata_out, 32'h7575_7575);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    ack_in_first = 1'b0;
    tick();
    checkOutput("rd1_ack_pulse", ack_out, 0);
    checkOutput("rd1_rdata_clr", rdata_out, 0);

    // Write to second slave; master inputs change and first slave acks while busy
    applyStimulus(1'b1, 32'hCCCC_CCCC, 1'b1, 32'hAAAA_AAAA);
    tick();
    checkOutput("wr2_req_second", req_out_second, 1);
    checkOutput("wr2_wdata_second", wdata_out_second, 32'hAAAA_AAAA);
    checkOutput("wr2_cmd_second", cmd_out_second, 1);
    checkOutput("wr2_req_first", req_out_first, 0);
    checkOutput("wr2_addr_first", addr_out_first, 0);
    checkOutput("wr2_wdata_first", wdata_out_first, 0);
    checkOutput("wr2_cmd_first", cmd_out_first, 0);
    applyStimulus(1'b1, 32'h0000_0004, 1'b0, 32'h1111_1111);
    ack_in_first = 1'b1;
    tick();
    checkOutput("wr2_addr_held", addr_out_second, 32'hCCCC_CCCC);
    checkOutput("wr2_wdata_held", wdata_out_second, 32'hAAAA_AAAA);
    checkOutput("wr2_other_ack_ignored", ack_out, 0);
    checkOutput("wr2_still_busy", req_out_second, 1);
    ack_in_first = 1'b0;
    ack_in_second = 1'b1; rdata_in_second = 32'h1234_5678;
    tick();
    checkOutput("wr2_ack", ack_out, 1);
    checkOutput("wr2_rdata_zero", rdata_out, 0);
    checkOutput("wr2_err", err_out, 0);
    checkOutput("wr2_req_drop", req_out_second, 0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    ack_in_second = 1'b0;
    tick();

    // Timeout: second slave never acks
    applyStimulus(1'b1, 32'h8000_0010, 1'b0, 32'h0);
    hi_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (req_out_second === 1'b1 && ack_out === 1'b0) hi_cycles++;
    end
    checkOutput("to_req_cycles", hi_cycles, 16);
    tick();
    checkOutput("to_ack", ack_out, 1);
    checkOutput("to_err", err_out, 1);
    checkOutput("to_rdata", rdata_out, 32'hDEAD_BEEF);
    checkOutput("to_req_drop", req_out_second, 0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    ack_in_second = 1'b1; rdata_in_second = 32'h5555_5555;
    tick();
    checkOutput("to_late_ack", ack_out, 0);
    checkOutput("to_late_req", req_out_second, 0);
    ack_in_second = 1'b0;
    tick();
    checkOutput("to_late_ack2", ack_out, 0);

    // Decode miss on the narrowed-window instance, then a hit in that window
    b_req_in = 1'b1; b_addr_in = 32'hC000_0000; b_cmd_in = 1'b0;
    tick();
    checkOutput("miss_ack", b_ack_out, 1);
    checkOutput("miss_err", b_err_out, 1);
    checkOutput("miss_rdata", b_rdata_out, 32'hDEAD_BEEF);
    checkOutput("miss_req_first", b_req_out_first, 0);
    checkOutput("miss_req_second", b_req_out_second, 0);
    b_req_in = 1'b0;
    tick();
    checkOutput("miss_ack_pulse", b_ack_out, 0);
    b_req_in = 1'b1; b_addr_in = 32'h9000_0004;
    tick();
    checkOutput("win_req_second", b_req_out_second, 1);
    b_req_in = 1'b0; b_ack_in_second = 1'b1;
    tick();
    checkOutput("win_ack", b_ack_out, 1);
    b_ack_in_second = 1'b0;
    tick();

    // Back-to-back: master re-raises req during the response cycle
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 32'h0);
    ack_in_first = 1'b1; rdata_in_first = 32'h1111_2222;
    tick();
    checkOutput("b2b_req_first", req_out_first, 1);
    tick();
    checkOutput("b2b_ack1", ack_out, 1);
    checkOutput("b2b_rdata1", rdata_out, 32'h1111_2222);
    ack_in_first = 1'b0;
    applyStimulus(1'b1, 32'h8000_0200, 1'b1, 32'h9999_9999);
    tick();
    checkOutput("b2b_resp_ignores_req", req_out_second, 0);
    checkOutput("b2b_no_ack", ack_out, 0);
    tick();
    checkOutput("b2b_accept2", req_out_second, 1);
    checkOutput("b2b_addr2", addr_out_second, 32'h8000_0200);
    ack_in_second = 1'b1;
    tick();
    checkOutput("b2b_ack2", ack_out, 1);
    checkOutput("b2b_rdata2", rdata_out, 0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    ack_in_second = 1'b0;
    tick();
    checkOutput("b2b_no_double_first", req_out_first, 0);
    checkOutput("b2b_no_double_second", req_out_second, 0);

    // Reset while the first slave request is outstanding
    applyStimulus(1'b1, 32'h0000_0040, 1'b0, 32'h0);
    tick();
    checkOutput("mrst_busy", req_out_first, 1);
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checkOutput("mrst_req_first", req_out_first, 0);
    checkOutput("mrst_addr_first", addr_out_first, 0);
    checkOutput("mrst_ack", ack_out, 0);
    rst = 1'b0;
    tick();
    checkOutput("mrst_no_ack", ack_out, 0);
    applyStimulus(1'b1, 32'h0000_0080, 1'b0, 32'h0);
    tick();
    checkOutput("mrst_idle_accept", req_out_first, 1);
    checkOutput("mrst_idle_addr", addr_out_first, 32'h0000_0080);
    ack_in_first = 1'b1; rdata_in_first = 32'h0BAD_F00D;
    tick();
    checkOutput("mrst_ack_after", rdata_out, 32'h0BAD_F00D);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    ack_in_first = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
